fir_out_requant: RTL and testbench

//  Sink end of the FIR output stream. Accepts the full-precision accumulator (o_valid/o_data,
//  no backpressure) and rounds it back to sample width. Saturates and buffers the samples in a

---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_sample_fifo.sv | 43 ++++
 rtl/fir_out_requant.sv | 88 ++++++++
 tb/tb_fir_out_requant.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared FIR datapath widths and the accumulator round-to-nearest helper.
package fir_pkg;
    localparam int NUM_TAPS      = 64;
    localparam int DATA_WIDTH    = 16;
    localparam int COEFF_WIDTH   = 16;
    localparam int PRODUCT_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int FIR_ACC_WIDTH = PRODUCT_WIDTH + $clog2(NUM_TAPS);

    // Round half up then drop 'shift' fraction bits; 64-bit headroom so the add never wraps.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int shift);
        return (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    endfunction
endpackage

// File: rtl/fir_sample_fifo.sv
// fir_sample_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             wr, rd;

    always_comb begin
        empty = wptr == rptr;
        full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        rd    = pop && !empty;
        wr    = push && (!full || rd);
        level = wptr - rptr;
        rdata = mem[rptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + (AW+1)'(wr);
            rptr <= rptr + (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: round/saturate FIR accumulator to sample width and buffer it on a ready/valid stream.
// Optional FIR_SAT_COUNT_EN adds the sat_count port counting clamped samples.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = FIR_ACC_WIDTH,
    parameter int OUT_WIDTH  = DATA_WIDTH,
    parameter int FRAC_SHIFT = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_valid,
    input  logic [IN_WIDTH-1:0]           i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [OUT_WIDTH-1:0]          o_data,
    output logic                          o_overflow,
    input  logic                          clr_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FIR_SAT_COUNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);
    localparam logic signed [IN_WIDTH:0] HI = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] LO = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic                        v1, v2;
    logic signed [IN_WIDTH:0]    r1;
    logic [OUT_WIDTH-1:0]        d2, head;
    logic                        sat_hi, sat_lo, full, empty, pop, drop;

    always_comb begin
        sat_hi  = r1 > HI;
        sat_lo  = r1 < LO;
        o_valid = !empty;
        o_data  = empty ? '0 : head;
        pop     = o_valid && o_ready;
        drop    = v2 && full && !pop;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            r1 <= '0;
            d2 <= '0;
        end else begin
            v1 <= i_valid;
            r1 <= (IN_WIDTH+1)'(sat_round({{(64-IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data}, FRAC_SHIFT));
            v2 <= v1;
            d2 <= sat_hi ? HI[OUT_WIDTH-1:0] : sat_lo ? LO[OUT_WIDTH-1:0] : r1[OUT_WIDTH-1:0];
        end
    end

    // A new drop outranks a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) o_overflow <= 1'b0;
        else         o_overflow <= drop ? 1'b1 : clr_overflow ? 1'b0 : o_overflow;
    end

`ifdef FIR_SAT_COUNT_EN
    logic s2;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2        <= 1'b0;
            sat_count <= '0;
        end else begin
            s2        <= sat_hi || sat_lo;
            sat_count <= clr_overflow ? 16'd0 :
                         (v2 && s2 && sat_count != 16'hFFFF) ? sat_count + 16'd1 : sat_count;
        end
    end
`endif

    fir_sample_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (v2),
        .pop    (pop),
        .wdata  (d2),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (fifo_level)
    );
endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed scenarios plus a randomized run against a queue-based model.
module tb_fir_out_requant;
    localparam int IW = 38, OW = 16, FS = 15, FD = 8;

    logic          clk = 1'b0, resetn = 1'b0, i_valid = 1'b0, o_ready = 1'b1, clr_overflow = 1'b0;
    logic [IW-1:0] i_data = '0;
    logic          o_valid, o_overflow;
    logic [OW-1:0] o_data;
    logic [3:0]    fifo_level;
`ifdef FIR_SAT_COUNT_EN
    logic [15:0]   sat_count;
`endif
    int errors = 0, checks = 0;

    fir_out_requant #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .o_ready      (o_ready),
        .o_data       (o_data),
        .o_overflow   (o_overflow),
        .clr_overflow (clr_overflow),
        .fifo_level   (fifo_level)
`ifdef FIR_SAT_COUNT_EN
        ,
        .sat_count    (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Nearest integer of x / 2**FS with ties toward +inf, by floor division.
    function automatic longint model_round(longint x);
        longint s = longint'(1) <<< FS;
        longint t = x + s / 2;
        longint q = t / s;
        if (t < 0 && t % s != 0) q = q - 1;
        return q;
    endfunction

    function automatic longint model_clamp(longint q);
        return q > 32767 ? 32767 : q < -32768 ? -32768 : q;
    endfunction

    task automatic drive(longint x);
        i_data = x[IW-1:0];
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
        checks++; if (o_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", o_data); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", o_overflow); end
`ifdef FIR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL reset_satcount: got %0d expected 0", sat_count); end
`endif
        resetn = 1'b1;
        step();
    endtask

    task automatic test_latency();
        o_ready = 1'b1;
        i_valid = 1'b1;
        drive(98304);
        step();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_plus1: got %0b expected 0", o_valid); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_plus2: got %0b expected 0", o_valid); end
        step();
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL lat_plus3: got %0b expected 1", o_valid); end
        checks++; if (o_data !== 16'd3) begin errors++; $display("FAIL lat_data: got %0d expected 3", $signed(o_data)); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_one_beat: got %0b expected 0", o_valid); end
    endtask

    task automatic test_rounding();
        longint ins [6] = '{16384, 16383, -16384, -16385, 40000 <<< 15, -(40000 <<< 15)};
        logic [OW-1:0] exps [6] = '{16'd1, 16'd0, 16'd0, 16'hFFFF, 16'h7FFF, 16'h8000};
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1'b1;
            drive(ins[i]);
            step();
            i_valid = 1'b0;
            step();
            step();
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %0b expected 1", i, o_valid); end
            checks++; if (o_data !== exps[i]) begin errors++; $display("FAIL round_data[%0d]: got %0d expected %0d", i, $signed(o_data), $signed(exps[i])); end
            step();
        end
`ifdef FIR_SAT_COUNT_EN
        checks++; if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_count: got %0d expected 2", sat_count); end
`endif
    endtask

    task automatic test_overflow();
        o_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            i_valid = 1'b1;
            drive(longint'(k) <<< FS);
            step();
        end
        i_valid = 1'b0;
        repeat (3) step();
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", o_overflow); end
        step();
        checks++; if (o_data !== 16'd1 || o_valid !== 1'b1) begin errors++; $display("FAIL ovf_hold: got %0d/%0b expected 1/1", o_data, o_valid); end
        o_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (o_valid !== 1'b1 || o_data !== OW'(k)) begin errors++; $display("FAIL ovf_drain[%0d]: got %0d/%0b expected %0d/1", k, o_data, o_valid, k); end
            step();
        end
        checks++; if (o_valid !== 1'b0 || fifo_level !== 4'd0 || o_data !== 16'd0) begin errors++; $display("FAIL ovf_empty: got v=%0b l=%0d d=%0d expected 0/0/0", o_valid, fifo_level, o_data); end
        checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", o_overflow); end
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", o_overflow); end
    endtask

    task automatic test_full_stream();
        int next_in = 1, next_out = 1;
        o_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            drive(longint'(next_in++) <<< FS);
            step();
        end
        o_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checks++; if (fifo_level !== 4'd8 || o_overflow !== 1'b0) begin errors++; $display("FAIL full_level[%0d]: got %0d/%0b expected 8/0", c, fifo_level, o_overflow); end
            checks++; if (o_data !== OW'(next_out)) begin errors++; $display("FAIL full_data[%0d]: got %0d expected %0d", c, o_data, next_out); end
            next_out++;
            i_valid = 1'b1;
            drive(longint'(next_in++) <<< FS);
            step();
        end
        i_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (o_valid) begin
                checks++; if (o_data !== OW'(next_out)) begin errors++; $display("FAIL full_drain: got %0d expected %0d", o_data, next_out); end
                next_out++;
            end
            step();
        end
        checks++; if (next_out != next_in) begin errors++; $display("FAIL full_count: got %0d expected %0d", next_out - 1, next_in - 1); end
        checks++; if (o_overflow !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL full_end: got %0b/%0d expected 0/0", o_overflow, fifo_level); end
    endtask

    task automatic test_reset_mid();
        o_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            i_valid = 1'b1;
            drive(longint'(k) <<< FS);
            step();
        end
        i_valid = 1'b0;
        repeat (3) step();
        checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mid_level: got %0d expected 5", fifo_level); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_data !== 16'd0 || fifo_level !== 4'd0) begin errors++; $display("FAIL mid_async: got v=%0b d=%0d l=%0d expected 0/0/0", o_valid, o_data, fifo_level); end
        step();
        resetn = 1'b1;
        o_ready = 1'b1;
        i_valid = 1'b1;
        drive(longint'(7) <<< FS);
        step();
        i_valid = 1'b0;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_plus1: got %0b expected 0", o_valid); end
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_plus2: got %0b expected 0", o_valid); end
        step();
        checks++; if (o_valid !== 1'b1 || o_data !== 16'd7) begin errors++; $display("FAIL mid_plus3: got %0b/%0d expected 1/7", o_valid, o_data); end
        step();
    endtask

    task automatic test_random();
        longint q [$];
        longint d1 = 0, d2 = 0, x, r, head;
        bit d1v = 0, d2v = 0, d1s = 0, d2s = 0, ovf = 0, pop, drop;
        int scnt = 0, mode;
        logic [OW-1:0] e;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        for (int c = 0; c < 400; c++) begin
            mode = $urandom_range(0, 2);
            r = {$urandom(), $urandom()};
            x = mode == 0 ? longint'(int'($urandom_range(0, 2000000)) - 1000000) :
                mode == 1 ? (r <<< 26) >>> 26 :
                (longint'(int'($urandom_range(0, 200)) - 100) <<< FS) + 16384 - longint'($urandom_range(0, 1));
            i_valid = $urandom_range(0, 9) < 7;
            o_ready = $urandom_range(0, 9) < 6;
            clr_overflow = $urandom_range(0, 19) == 0;
            drive(x);
            head = q.size() != 0 ? q[0] : 0;
            e = head[OW-1:0];
            checks++; if (o_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", c, o_valid, q.size() != 0); end
            checks++; if (o_data !== e) begin errors++; $display("FAIL rnd_data[%0d]: got %0d expected %0d", c, $signed(o_data), $signed(e)); end
            checks++; if (fifo_level !== 4'(q.size())) begin errors++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", c, fifo_level, q.size()); end
            checks++; if (o_overflow !== ovf) begin errors++; $display("FAIL rnd_overflow[%0d]: got %0b expected %0b", c, o_overflow, ovf); end
`ifdef FIR_SAT_COUNT_EN
            checks++; if (sat_count !== 16'(scnt)) begin errors++; $display("FAIL rnd_satcount[%0d]: got %0d expected %0d", c, sat_count, scnt); end
`endif
            pop = q.size() != 0 && o_ready;
            drop = d2v && q.size() == FD && !pop;
            if (pop) void'(q.pop_front());
            if (d2v && !drop) q.push_back(d2);
            ovf = drop ? 1'b1 : clr_overflow ? 1'b0 : ovf;
            scnt = clr_overflow ? 0 : (d2v && d2s && scnt != 65535) ? scnt + 1 : scnt;
            d2v = d1v; d2 = d1; d2s = d1s;
            d1v = i_valid;
            d1 = model_clamp(model_round(x));
            d1s = d1 != model_round(x);
            step();
        end
        i_valid = 1'b0;
        clr_overflow = 1'b0;
        o_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_overflow();
        test_full_stream();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
